memory_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of `memory_4x3` and turns it into a 4-entry FIFO.
- Accepts words on a valid/ready push interface and drives the array's `en`/`rw_bar`/`sel`/`data_in` pins, one access per cycle, with fair write/read arbitration.
- Prefetches the oldest word through the array's combinational `data_out` into a one-entry output register, which feeds a valid/ready pop interface.

---
 rtl/memory_fifo_pkg.sv | 20 ++
 rtl/memory_fifo_arb.sv | 23 ++
 rtl/memory_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_memory_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_fifo_pkg.sv
// Shared constants, op encoding and pointer helper for the memory_4x3 FIFO controller.
package memory_fifo_pkg;

  localparam int FIFO_WIDTH = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;

  typedef enum logic [1:0] {
    OP_IDLE   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_READ   = 2'd2,
    OP_BYPASS = 2'd3
  } fifo_op_e;

  // Pointers are log2(DEPTH) wide, so plain increment wraps modulo DEPTH.
  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] ptr);
    return ptr + FIFO_PTR_W'(1);
  endfunction

endpackage

// File: rtl/memory_fifo_arb.sv
// Combinational op select: one array access per cycle, reads and writes alternate under contention.
module memory_fifo_arb
  import memory_fifo_pkg::*;
(
  input  logic     i_rd_need,
  input  logic     i_wr_req,
  input  logic     i_last_rd,
  input  logic     i_byp_ok,
  output fifo_op_e o_op
);

  always_comb begin
    o_op = OP_IDLE;
    if (i_byp_ok) begin
      o_op = OP_BYPASS;
    end else if (i_rd_need && (!i_wr_req || !i_last_rd)) begin
      o_op = OP_READ;
    end else if (i_wr_req) begin
      o_op = OP_WRITE;
    end
  end

endmodule

// File: rtl/memory_fifo_ctrl.sv
// FIFO controller driving a memory_4x3 array, with a prefetched one-entry output register.
// Optional feature: define MEMORY_FIFO_BYPASS_EN to let a push into an empty FIFO load rd_data directly.
module memory_fifo_ctrl
  import memory_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     mem_en,
  output logic                     mem_rw_bar,
  output logic [$clog2(DEPTH)-1:0] mem_sel,
  output logic [WIDTH-1:0]         mem_data_in,
  input  logic [WIDTH-1:0]         mem_data_out,
  output logic [2:0]               level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_last_rd;
  logic [WIDTH-1:0] r_rd_data;

  logic     w_empty;
  logic     w_full;
  logic     w_pop;
  logic     w_rd_need;
  logic     w_wr_req;
  logic     w_byp_ok;
  fifo_op_e w_op;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = r_out_valid && rd_ready;
  assign w_rd_need = !w_empty && (!r_out_valid || w_pop);
  // Gated by rst_n so the array pins fall idle the moment reset asserts.
  assign w_wr_req  = rst_n && wr_valid && !w_full;

`ifdef MEMORY_FIFO_BYPASS_EN
  assign w_byp_ok = w_wr_req && w_empty && (!r_out_valid || w_pop);
`else
  assign w_byp_ok = 1'b0;
`endif

  memory_fifo_arb u_arb (
    .i_rd_need (w_rd_need),
    .i_wr_req  (w_wr_req),
    .i_last_rd (r_last_rd),
    .i_byp_ok  (w_byp_ok),
    .o_op      (w_op)
  );

  assign wr_ready = rst_n && !w_full && (w_op != OP_READ);
  assign rd_valid = r_out_valid;
  assign rd_data  = r_rd_data;
  assign level    = 3'(r_count) + 3'(r_out_valid);

  always_comb begin
    mem_en      = 1'b0;
    mem_rw_bar  = 1'b0;
    mem_sel     = '0;
    mem_data_in = '0;
    case (w_op)
      OP_WRITE: begin
        mem_en      = 1'b1;
        mem_rw_bar  = 1'b1;
        mem_sel     = r_wr_ptr;
        mem_data_in = wr_data;
      end
      OP_READ: begin
        mem_en  = 1'b1;
        mem_sel = r_rd_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_last_rd   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (w_rd_need && w_wr_req) begin
        r_last_rd <= (w_op == OP_READ);
      end
      case (w_op)
        OP_WRITE: begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          r_count  <= r_count + CNT_W'(1);
        end
        OP_READ: begin
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
          r_count   <= r_count - CNT_W'(1);
          r_rd_data <= mem_data_out;
        end
        OP_BYPASS: begin
          r_rd_data <= wr_data;
        end
        default: ;
      endcase
      // A pop that is not refilled in the same cycle empties the output register.
      if ((w_op == OP_READ) || (w_op == OP_BYPASS)) begin
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_fifo_ctrl.sv
// Self-checking bench for memory_fifo_ctrl with a behavioural queue model and a memory_4x3 stand-in.
module tb_memory_fifo_ctrl;

`ifdef MEMORY_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH_M = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] rd_data;
  logic       mem_en;
  logic       mem_rw_bar;
  logic [1:0] mem_sel;
  logic [2:0] mem_data_in;
  logic [2:0] mem_data_out;
  logic [2:0] level;

  memory_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .mem_en       (mem_en),
    .mem_rw_bar   (mem_rw_bar),
    .mem_sel      (mem_sel),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .level        (level)
  );

  always #5 clk = ~clk;

  // memory_4x3 stand-in: combinational read, write on the rising edge, stale contents at start.
  logic [2:0] mem_arr [4] = '{3'd7, 3'd7, 3'd7, 3'd7};
  assign mem_data_out = mem_arr[mem_sel];
  always @(posedge clk) if (mem_en && mem_rw_bar) mem_arr[mem_sel] <= mem_data_in;

  // Behavioural model: words stored in the array, plus the output register.
  int unsigned q[$];
  int unsigned popq[$];
  bit          m_ov;
  int unsigned m_od;
  bit          m_last;
  int          m_wp, m_rp;
  bit          last_acc;
  bit          last_mem_en;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ov = 0; m_od = 0; m_last = 0; m_wp = 0; m_rp = 0;
  endtask

  // One clock cycle: drive, compare outputs with the model, then advance the model at the edge.
  task automatic step(input logic wv, input logic [2:0] wd, input logic rr);
    int op;
    bit pop, need, wreq, byp;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    pop  = m_ov && rr;
    need = (q.size() != 0) && (!m_ov || pop);
    wreq = wv && (q.size() != DEPTH_M);
    byp  = BYP && wreq && (q.size() == 0) && (!m_ov || pop);
    if (byp) op = 3;
    else if (need && (!wreq || !m_last)) op = 2;
    else if (wreq) op = 1;
    else op = 0;
    chk("wr_ready", int'(wr_ready), int'(q.size() != DEPTH_M && op != 2));
    chk("rd_valid", int'(rd_valid), int'(m_ov));
    if (m_ov) chk("rd_data", int'(rd_data), int'(m_od));
    chk("level", int'(level), int'(q.size()) + int'(m_ov));
    chk("mem_en", int'(mem_en), int'(op == 1 || op == 2));
    chk("mem_rw_bar", int'(mem_rw_bar), int'(op == 1));
    chk("mem_sel", int'(mem_sel), (op == 1) ? m_wp : (op == 2) ? m_rp : 0);
    if (op != 2) chk("mem_data_in", int'(mem_data_in), (op == 1) ? int'(wd) : 0);
    last_acc    = wv && (op == 1 || op == 3);
    last_mem_en = mem_en;
    if (pop) popq.push_back(m_od);
    @(posedge clk);
    if (need && wreq) m_last = (op == 2);
    case (op)
      1: begin q.push_back(int'(wd)); m_wp = (m_wp + 1) % DEPTH_M; end
      2: begin m_od = q.pop_front(); m_rp = (m_rp + 1) % DEPTH_M; end
      3: m_od = int'(wd);
      default: ;
    endcase
    if (op == 2 || op == 3) m_ov = 1;
    else if (pop) m_ov = 0;
  endtask

  task automatic push_hold(input logic [2:0] wd);
    int tries = 0;
    last_acc = 0;
    while (!last_acc && tries < 10) begin
      step(1'b1, wd, 1'b0);
      tries++;
    end
    if (!last_acc) chk("push_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pend;
    int         exp_seq [5] = '{5, 6, 3, 0, 7};
    int         tries;

    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 3'd2; rd_ready = 1'b1;
    m_reset();
    #12;
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fill: 5,6,3,0 with the consumer stalled, then 7 fills the array.
    push_hold(3'd5); push_hold(3'd6); push_hold(3'd3); push_hold(3'd0);
    #1;
    chk("fill_level4", int'(level), 4);
    chk("fill_rd_valid", int'(rd_valid), 1);
    chk("fill_rd_data", int'(rd_data), 5);
    push_hold(3'd7);
    #1;
    chk("full_level5", int'(level), 5);
    chk("full_wr_ready", int'(wr_ready), 0);
    step(1'b1, 3'd1, 1'b0);

    // Drain in order.
    popq.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 1'b1);
    #1;
    chk("drain_level", int'(level), 0);
    chk("drain_rd_valid", int'(rd_valid), 0);
    chk("drain_count", popq.size(), 5);
    for (int i = 0; i < 5 && i < popq.size(); i++) chk("drain_order", int'(popq[i]), exp_seq[i]);

    // Both sides saturated from reset; pointers wrap many times.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b1);

    // Reset mid-stream with two words in the array and a push in flight.
    do_reset();
    tries = 0;
    while (q.size() != 2 && tries < 20) begin
      step(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      tries++;
    end
    chk("midrst_count2", q.size(), 2);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 3'd5; rd_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", int'(mem_en), 0);
    chk("midrst_wr_ready", int'(wr_ready), 0);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_level", int'(level), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    chk("postrst_level", int'(level), 0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    #1;
    chk("postrst_rd_valid", int'(rd_valid), 1);
    chk("postrst_rd_data", int'(rd_data), 1);

    // Push-to-rd_valid latency on an empty FIFO.
    do_reset();
    step(1'b1, 3'd4, 1'b0);
    chk("lat_mem_en", int'(last_mem_en), BYP ? 0 : 1);
    #1;
    chk("lat_cycle1_valid", int'(rd_valid), BYP ? 1 : 0);
    if (BYP) chk("lat_cycle1_data", int'(rd_data), 4);
    step(1'b0, 3'd0, 1'b0);
    #1;
    chk("lat_cycle2_valid", int'(rd_valid), 1);
    chk("lat_cycle2_data", int'(rd_data), 4);

    // Randomized traffic; producer holds its word until accepted.
    do_reset();
    pend = 3'($urandom_range(0, 7));
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic wv, rr;
        wv = (ph == 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0);
        rr = (ph == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
        step(wv, pend, rr);
        if (last_acc) pend = 3'($urandom_range(0, 7));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
